// File: rtl/stopwatch_pkg.sv
// Shared definitions for the MM:SS.hh stopwatch: FSM encodings, BCD digit
// width and limits, and digit field offsets within bcd_out.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned UNIT_MAX = 9;
  localparam int unsigned TENS_MAX = 5;

  localparam int unsigned HUN_U_LSB = 0;
  localparam int unsigned HUN_T_LSB = 4;
  localparam int unsigned SEC_U_LSB = 8;
  localparam int unsigned SEC_T_LSB = 12;
  localparam int unsigned MIN_U_LSB = 16;
  localparam int unsigned MIN_T_LSB = 20;
  localparam int unsigned BCD_W     = 6 * DIGIT_W;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counting 0..MAX; carry flags the increment that rolls the
// digit back to zero so digits can be chained.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = UNIT_MAX
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  logic [DIGIT_W-1:0] q_q, q_d;
  logic               at_max;

  assign at_max = (q_q == DIGIT_W'(MAX));
  assign carry  = inc & at_max;
  assign q      = q_q;

  always_comb begin
    q_d = q_q;
    if (clr)      q_d = '0;
    else if (inc) q_d = at_max ? '0 : q_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= '0;
    else        q_q <= q_d;
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// MM:SS.hh stopwatch driven by the divided tick; optional lap hold enabled
// with STOPWATCH_LAP_HOLD_EN.
//   state    | meaning
//   ST_IDLE  | cleared, digits and prescaler at zero
//   ST_RUN   | counting tick rises
//   ST_PAUSE | digits and prescaler frozen
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned PRESCALE = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             start_stop,
  input  logic             clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic             lap,
`endif
  output logic [BCD_W-1:0] bcd_out,
  output logic             running,
  output logic             wrap
);

  localparam logic [9:0] PRE_LAST = 10'(PRESCALE - 1);

  sw_state_e        state_q;
  logic             running_q, wrap_q, tick_d_q;
  logic [9:0]       pre_q, pre_d;
  logic             rise, in_run, pre_at_last, step;
  logic [5:0]       carry;
  logic [BCD_W-1:0] live;

  assign rise        = tick_in & ~tick_d_q;
  assign in_run      = (state_q == ST_RUN);
  assign pre_at_last = (pre_q == PRE_LAST);
  // clear outranks any rise landing in the same cycle
  assign step        = rise & in_run & ~clear & pre_at_last;

  always_comb begin
    pre_d = pre_q;
    if (clear)             pre_d = '0;
    else if (in_run && rise) pre_d = pre_at_last ? 10'd0 : pre_q + 10'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
    end else if (clear) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
    end else if (start_stop) begin
      case (state_q)
        ST_RUN: begin
          state_q   <= ST_PAUSE;
          running_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_RUN;
          running_q <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_d_q <= 1'b0;
      pre_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      tick_d_q <= tick_in;
      pre_q    <= pre_d;
      wrap_q   <= carry[5];
    end
  end

  bcd_digit_cnt #(.MAX(UNIT_MAX)) u_hun_u (.clk(clk), .reset(reset), .inc(step),
    .clr(clear), .q(live[HUN_U_LSB +: DIGIT_W]), .carry(carry[0]));
  bcd_digit_cnt #(.MAX(UNIT_MAX)) u_hun_t (.clk(clk), .reset(reset), .inc(carry[0]),
    .clr(clear), .q(live[HUN_T_LSB +: DIGIT_W]), .carry(carry[1]));
  bcd_digit_cnt #(.MAX(UNIT_MAX)) u_sec_u (.clk(clk), .reset(reset), .inc(carry[1]),
    .clr(clear), .q(live[SEC_U_LSB +: DIGIT_W]), .carry(carry[2]));
  bcd_digit_cnt #(.MAX(TENS_MAX)) u_sec_t (.clk(clk), .reset(reset), .inc(carry[2]),
    .clr(clear), .q(live[SEC_T_LSB +: DIGIT_W]), .carry(carry[3]));
  bcd_digit_cnt #(.MAX(UNIT_MAX)) u_min_u (.clk(clk), .reset(reset), .inc(carry[3]),
    .clr(clear), .q(live[MIN_U_LSB +: DIGIT_W]), .carry(carry[4]));
  bcd_digit_cnt #(.MAX(TENS_MAX)) u_min_t (.clk(clk), .reset(reset), .inc(carry[4]),
    .clr(clear), .q(live[MIN_T_LSB +: DIGIT_W]), .carry(carry[5]));

  assign running = running_q;
  assign wrap    = wrap_q;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic             hold_q;
  logic [BCD_W-1:0] snap_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else if (clear) begin
      hold_q <= 1'b0;
    end else if (lap && in_run) begin
      hold_q <= ~hold_q;
      if (!hold_q) snap_q <= live;
    end
  end

  assign bcd_out = hold_q ? snap_q : live;
`else
  assign bcd_out = live;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter at PRESCALE=2; lap hold steps are
// exercised when STOPWATCH_LAP_HOLD_EN is defined.
module tb_stopwatch_bcd_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_in;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [23:0] bcd_out;
  logic        running;
  logic        wrap;
  logic [23:0] force_val;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stopwatch_bcd_counter #(.PRESCALE(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_in    (tick_in),
    .start_stop (start_stop),
    .clear      (clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap        (lap),
`endif
    .bcd_out    (bcd_out),
    .running    (running),
    .wrap       (wrap)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rises(input int n);
    repeat (n) begin
      tick_in = 1'b1;
      cyc(5);
      tick_in = 1'b0;
      cyc(5);
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
  endtask

  task automatic force_digits(input logic [23:0] v);
    force_val = v;
    force dut.u_min_t.q_q = force_val[23:20];
    force dut.u_min_u.q_q = force_val[19:16];
    force dut.u_sec_t.q_q = force_val[15:12];
    force dut.u_sec_u.q_q = force_val[11:8];
    force dut.u_hun_t.q_q = force_val[7:4];
    force dut.u_hun_u.q_q = force_val[3:0];
    #1;
    release dut.u_min_t.q_q;
    release dut.u_min_u.q_q;
    release dut.u_sec_t.q_q;
    release dut.u_sec_u.q_q;
    release dut.u_hun_t.q_q;
    release dut.u_hun_u.q_q;
  endtask

  initial begin
    reset = 1'b0; tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    force_val = '0;

    // reset held while the tick keeps toggling
    cyc(2);
    start_stop = 1'b1;
    rises(3);
    start_stop = 1'b0;
    check("reset_bcd", bcd_out, 24'h000000);
    check("reset_running", {23'd0, running}, 24'd1 - 24'd1);
    check("reset_wrap", {23'd0, wrap}, 24'h000000);
    reset = 1'b1;
    cyc(2);

    // run 20 rises = 10 steps, then one more rise leaves pre at 1
    pulse_ss();
    check("run_running", {23'd0, running}, 24'h000001);
    rises(20);
    check("run_20", bcd_out, 24'h000010);
    rises(1);
    check("run_21", bcd_out, 24'h000010);

    // pause holds everything, resume finishes the pending prescale
    pulse_ss();
    check("pause_running", {23'd0, running}, 24'h000000);
    rises(6);
    check("pause_hold", bcd_out, 24'h000010);
    pulse_ss();
    check("resume_running", {23'd0, running}, 24'h000001);
    rises(1);
    check("resume_r1", bcd_out, 24'h000011);
    rises(1);
    check("resume_r2", bcd_out, 24'h000011);

    // carry chain from 09:59.99 and wrap from 59:59.99
    pulse_clear();
    check("clear_bcd", bcd_out, 24'h000000);
    check("clear_running", {23'd0, running}, 24'h000000);
    pulse_ss();
    force_digits(24'h095999);
    rises(2);
    check("carry_min", bcd_out, 24'h100000);
    check("carry_nowrap", {23'd0, wrap}, 24'h000000);
    force_digits(24'h595999);
    rises(1);
    check("edge_pre", bcd_out, 24'h595999);
    tick_in = 1'b1;
    cyc(1);
    check("wrap_bcd", bcd_out, 24'h000000);
    check("wrap_high", {23'd0, wrap}, 24'h000001);
    cyc(1);
    check("wrap_one_cycle", {23'd0, wrap}, 24'h000000);
    cyc(3);
    tick_in = 1'b0;
    cyc(5);

    // clear beats start_stop and a rise in the same cycle
    rises(4);
    check("pre_clear_bcd", bcd_out, 24'h000002);
    rises(1);
    tick_in = 1'b1; start_stop = 1'b1; clear = 1'b1;
    cyc(1);
    start_stop = 1'b0; clear = 1'b0;
    check("clr_win_bcd", bcd_out, 24'h000000);
    check("clr_win_running", {23'd0, running}, 24'h000000);
    check("clr_win_pre", {14'd0, dut.pre_q}, 24'h000000);
    cyc(4);
    tick_in = 1'b0;
    cyc(5);
    pulse_ss();
    rises(1);
    check("clr_pre_zero", bcd_out, 24'h000000);
    rises(1);
    check("clr_after_step", bcd_out, 24'h000001);

`ifdef STOPWATCH_LAP_HOLD_EN
    pulse_clear();
    pulse_ss();
    rises(10);
    check("lap_live", bcd_out, 24'h000005);
    pulse_lap();
    rises(10);
    check("lap_hold", bcd_out, 24'h000005);
    pulse_lap();
    check("lap_release", bcd_out, 24'h000010);
`endif

    // asynchronous reset mid-run
    rises(3);
    reset = 1'b0;
    #1;
    check("async_bcd", bcd_out, 24'h000000);
    check("async_running", {23'd0, running}, 24'h000000);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
